// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter sharing one FIFO push port among N_REQ producers.
// Define FIFO_ARB_STATS_EN to add per-requester accepted-word counters (stat_words).

`ifdef FIFO_ARB_STATS_EN
module fifo_arb_stat_ctr (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && count != 16'hFFFF)
            count <= count + 16'd1;
    end
endmodule
`endif

module fifo_push_arbiter #(
    parameter int N_BITS    = 8,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*N_BITS-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        gnt,
    input  logic                    fifo_full,
    output logic                    fifo_push,
    output logic [N_BITS-1:0]       fifo_data,
    output logic                    busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]     stat_words
`endif
);
    localparam int OWN_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state, state_nx;
    logic [OWN_W-1:0]   owner, owner_nx;
    logic [OWN_W-1:0]   rr_ptr, rr_ptr_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [OWN_W-1:0]   pick;
    logic               pick_vld;
    logic [OWN_W-1:0]   owner_inc;
    logic               last_hit;

    // First requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_vld && req[(int'(rr_ptr) + i) % N_REQ]) begin
                pick_vld = 1'b1;
                pick     = OWN_W'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    assign owner_inc = (owner == OWN_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign last_hit  = req_last[owner] | (cnt == CNT_W'(MAX_BURST - 1));

    assign busy      = (state == BURST);
    assign gnt       = busy ? (N_REQ'(1) << owner) : '0;
    assign fifo_push = busy & req[owner] & ~fifo_full & ~rst;
    assign ack       = gnt & {N_REQ{fifo_push}};
    assign fifo_data = req_data[owner*N_BITS +: N_BITS];

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        rr_ptr_nx = rr_ptr;
        cnt_nx    = cnt;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    owner_nx = pick;
                    cnt_nx   = '0;
                    state_nx = BURST;
                end
            end
            BURST: begin
                // A stalled owner (full FIFO, req still high) keeps the port.
                if (fifo_push) begin
                    cnt_nx = cnt + 1'b1;
                    if (last_hit) begin
                        state_nx  = IDLE;
                        rr_ptr_nx = owner_inc;
                    end
                end else if (!req[owner]) begin
                    state_nx  = IDLE;
                    rr_ptr_nx = owner_inc;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            owner  <= owner_nx;
            rr_ptr <= rr_ptr_nx;
            cnt    <= cnt_nx;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        fifo_arb_stat_ctr u_stat (
            .clk   (clk),
            .rst   (rst),
            .inc   (ack[g]),
            .count (stat_words[g*16 +: 16])
        );
    end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: directed bursts plus randomized traffic against
// a transaction-level owner/pointer model.

module tb_fifo_push_arbiter;
    localparam int N_BITS    = 8;
    localparam int N_REQ     = 4;
    localparam int MAX_BURST = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*N_BITS-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        gnt;
    logic                    fifo_full;
    logic                    fifo_push;
    logic [N_BITS-1:0]       fifo_data;
    logic                    busy;
`ifdef FIFO_ARB_STATS_EN
    logic [N_REQ*16-1:0]     stat_words;
`endif

    fifo_push_arbiter #(.N_BITS(N_BITS), .N_REQ(N_REQ), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .req_last  (req_last),
        .ack       (ack),
        .gnt       (gnt),
        .fifo_full (fifo_full),
        .fifo_push (fifo_push),
        .fifo_data (fifo_data),
        .busy      (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_words(stat_words)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: current owner (-1 = none), next search start,
    // words taken in this ownership, per-requester accepted words.
    int m_own = -1;
    int m_rr  = 0;
    int m_taken = 0;
    int m_stat [N_REQ];
    logic [N_REQ-1:0]  last_ack;
    logic [N_BITS-1:0] pushed_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    // Called just after a negedge with inputs applied; ends at the next negedge.
    task automatic step();
        logic             e_push;
        logic [N_REQ-1:0] e_ack, e_gnt;
        #1;
        e_push = (m_own >= 0) ? (req[m_own] && !fifo_full && !rst) : 1'b0;
        e_gnt  = (m_own >= 0) ? N_REQ'(1 << m_own) : '0;
        e_ack  = e_push ? e_gnt : '0;
        chk("push", fifo_push, e_push);
        chk("ack", ack, e_ack);
        if (!rst) begin
            chk("gnt", gnt, e_gnt);
            chk("busy", busy, m_own >= 0);
        end
        if (e_push) begin
            chk("data", fifo_data, req_data[m_own*N_BITS +: N_BITS]);
            pushed_q.push_back(fifo_data);
        end
`ifdef FIFO_ARB_STATS_EN
        begin
            logic [N_REQ*16-1:0] e_sw;
            for (int i = 0; i < N_REQ; i++) e_sw[i*16 +: 16] = 16'(m_stat[i]);
            chk("stats", stat_words, e_sw);
        end
`endif
        @(posedge clk);
        if (rst) begin
            m_own = -1; m_rr = 0; m_taken = 0;
            for (int i = 0; i < N_REQ; i++) m_stat[i] = 0;
        end else if (m_own < 0) begin
            for (int i = 0; i < N_REQ; i++) begin
                automatic int j = (m_rr + i) % N_REQ;
                if (m_own < 0 && req[j]) begin
                    m_own = j;
                    m_taken = 0;
                end
            end
        end else if (e_push) begin
            m_taken++;
            if (m_stat[m_own] < 65535) m_stat[m_own]++;
            if (req_last[m_own] || m_taken == MAX_BURST) begin
                m_rr = (m_own + 1) % N_REQ;
                m_own = -1;
            end
        end else if (!req[m_own]) begin
            m_rr = (m_own + 1) % N_REQ;
            m_own = -1;
        end
        last_ack = e_ack;
        @(negedge clk);
    endtask

    // Producers only change a word after it is acked (or while not requesting).
    task automatic rand_inputs(input int p_req, input int p_last, input int p_full, input int p_rst);
        for (int i = 0; i < N_REQ; i++) begin
            if (!req[i] || last_ack[i] || rst) begin
                req[i]                   = ($urandom_range(99) < p_req);
                req_data[i*N_BITS +: N_BITS] = N_BITS'($urandom);
                req_last[i]              = ($urandom_range(99) < p_last);
            end
        end
        fifo_full = ($urandom_range(99) < p_full);
        rst       = ($urandom_range(999) < p_rst);
    endtask

    initial begin
        rst = 1'b1; req = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
        last_ack = '0;
        for (int i = 0; i < N_REQ; i++) m_stat[i] = 0;
        @(negedge clk);
        step();
        rst = 1'b0;
        step();
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_push", fifo_push, 0);

        // Single requester: 11 then 22+last.
        req[0] = 1'b1; req_data[7:0] = 8'h11;
        step();
        chk("single_gnt", gnt, 4'b0001);
        chk("single_d0", fifo_data, 8'h11);
        step();
        req_data[7:0] = 8'h22; req_last[0] = 1'b1;
        #1 chk("single_d1", fifo_data, 8'h22);
        step();
        chk("single_idle", busy, 0);
        req = 4'b0011; req_data[7:0] = 8'h33; req_data[15:8] = 8'h44; req_last = 4'b0011;
        step();
        chk("rr_after_single", gnt, 4'b0010);
        for (int c = 0; c < 4; c++) begin
            if (last_ack[0]) req[0] = 1'b0;
            if (last_ack[1]) req[1] = 1'b0;
            step();
        end
        req = '0; req_last = '0;
        step(); step();

        // Burst cap with a full stall inside: words A0..A5 from requester 2.
        pushed_q.delete();
        begin
            int k = 0;
            for (int c = 0; c < 30; c++) begin
                req[2] = (k < 6);
                req_data[2*N_BITS +: N_BITS] = 8'(8'hA0 + k);
                fifo_full = (c >= 4 && c < 7);
                step();
                if (last_ack[2]) k++;
            end
        end
        chk("cap_count", pushed_q.size(), 6);
        for (int i = 0; i < 6 && i < pushed_q.size(); i++)
            chk("cap_word", pushed_q[i], 8'(8'hA0 + i));
        req = '0; fifo_full = 1'b0;
        step();

        // Randomized traffic: busy, bursty, stall-heavy, with occasional resets.
        for (int c = 0; c < 2000; c++) begin rand_inputs(90, 30, 10, 5);  step(); end
        for (int c = 0; c < 2000; c++) begin rand_inputs(60, 10, 40, 10); step(); end
        for (int c = 0; c < 2000; c++) begin rand_inputs(40, 60, 5, 2);   step(); end
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
